minterm_sweeper: RTL and testbench



---
 rtl/minterm_sweeper_if.sv | 52 +++++
 rtl/minterm_sweeper.sv | 108 ++++++++++
 tb/tb_minterm_sweeper.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minterm_sweeper_if.sv
// Stimulus/capture bundle between the sweeper and a 4-input function block.
// SWEEP_CHECK_EN adds the expected-table input and match/mismatch outputs.
interface minterm_sweeper_if;
  logic        start;
  logic        f;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        busy;
  logic        done;
  logic [15:0] tt;
`ifdef SWEEP_CHECK_EN
  logic [15:0] expected;
  logic        match;
  logic [4:0]  mismatch_cnt;
`endif

  modport master (
`ifdef SWEEP_CHECK_EN
    input  expected,
    output match,
    output mismatch_cnt,
`endif
    input  start,
    input  f,
    output A,
    output B,
    output C,
    output D,
    output busy,
    output done,
    output tt
  );

  modport slave (
`ifdef SWEEP_CHECK_EN
    output expected,
    input  match,
    input  mismatch_cnt,
`endif
    output start,
    output f,
    input  A,
    input  B,
    input  C,
    input  D,
    input  busy,
    input  done,
    input  tt
  );
endinterface

// File: rtl/minterm_sweeper.sv
// Sweeps A..D through minterms 0..15, holding each DWELL cycles, and builds tt.
// Optional SWEEP_CHECK_EN compares each sample against an expected table.
module minterm_sweeper #(
  parameter int unsigned DWELL = 20
) (
  input logic              clk,
  input logic              rst,
  minterm_sweeper_if.master bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] tt_q, tt_d;

  logic accept;
  logic sample;

  assign accept = (state_q != SWEEP) && bus.start;
  assign sample = (state_q == SWEEP) && (dwell_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tt_d    = tt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = SWEEP;
          idx_d   = '0;
          dwell_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          tt_d    = '0;
        end
      end
      SWEEP: begin
        if (sample) begin
          tt_d[idx_q] = bus.f;
          dwell_d     = '0;
          // index wraps to 0, so A..D read back 0 once done
          idx_d       = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {bus.A, bus.B, bus.C, bus.D} = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tt   = tt_q;

`ifdef SWEEP_CHECK_EN
  logic [4:0] mis_q, mis_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= '0;
    else     mis_q <= mis_d;
  end

  always_comb begin
    mis_d = mis_q;
    if (accept)
      mis_d = '0;
    else if (sample && (bus.f != bus.expected[idx_q]) && (mis_q != 5'd16))
      mis_d = mis_q + 5'd1;
  end

  assign bus.mismatch_cnt = mis_q;
  assign bus.match        = (mis_q == 5'd0) && done_q;
`endif

endmodule

// File: tb/tb_minterm_sweeper.sv
// Directed bench: two sweepers (DWELL=20 and DWELL=1) driving a modelled f.
// Enable SWEEP_CHECK_EN to also exercise the expected-table checker.
module tb_minterm_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fmode = 2'd0;
  int         n_chk = 0;
  int         n_fail = 0;

  minterm_sweeper_if b0 ();
  minterm_sweeper_if b1 ();

  minterm_sweeper #(.DWELL(20)) u0 (.clk(clk), .rst(rst), .bus(b0));
  minterm_sweeper #(.DWELL(1))  u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  function automatic logic fn(input logic [1:0] m, input logic [3:0] v);
    case (m)
      2'd0:    return v[3] & v[2];
      2'd1:    return ^v;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign b0.f = fn(fmode, {b0.A, b0.B, b0.C, b0.D});
  assign b1.f = fn(fmode, {b1.A, b1.B, b1.C, b1.D});

  // Pulses start on one DUT and counts edges after the accepting edge until done.
  task automatic sweep(input bit which, output int len, output logic [15:0] tto);
    @(negedge clk);
    if (which) b1.start = 1'b1;
    else       b0.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    len = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (which ? b1.done : b0.done) begin
        len = k;
        break;
      end
    end
    tto = which ? b1.tt : b0.tt;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({b0.A, b0.B, b0.C, b0.D, b0.busy, b0.done, b0.tt} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_dw20 got %h exp 0",
               {b0.A, b0.B, b0.C, b0.D, b0.busy, b0.done, b0.tt});
    end
    n_chk++;
    if ({b1.A, b1.B, b1.C, b1.D, b1.busy, b1.done, b1.tt} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_dw1 got %h exp 0",
               {b1.A, b1.B, b1.C, b1.D, b1.busy, b1.done, b1.tt});
    end
  endtask

  task automatic test_and_dw20();
    logic [3:0] v;
    fmode = 2'd0;
    @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    v = {b0.A, b0.B, b0.C, b0.D};
    n_chk++;
    if (b0.busy !== 1'b1 || v !== 4'd0) begin
      n_fail++;
      $display("FAIL accept_edge got busy=%b v=%h exp busy=1 v=0", b0.busy, v);
    end
    for (int k = 1; k <= 320; k++) begin
      @(posedge clk);
      #1;
      v = {b0.A, b0.B, b0.C, b0.D};
      if (k < 320 && (k % 20 == 0 || k % 20 == 19)) begin
        n_chk++;
        if (v !== 4'(k / 20)) begin
          n_fail++;
          $display("FAIL vector k=%0d got %h exp %h", k, v, 4'(k / 20));
        end
      end
      if (k == 319) begin
        n_chk++;
        if (b0.done !== 1'b0 || b0.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL early_done got done=%b busy=%b exp 0/1", b0.done, b0.busy);
        end
      end
    end
    n_chk++;
    if (b0.done !== 1'b1 || b0.busy !== 1'b0 || v !== 4'd0) begin
      n_fail++;
      $display("FAIL end_state got done=%b busy=%b v=%h exp 1/0/0", b0.done, b0.busy, v);
    end
    n_chk++;
    if (b0.tt !== 16'hF000) begin
      n_fail++;
      $display("FAIL tt_and got %h exp F000", b0.tt);
    end
  endtask

  task automatic test_xor_dw1();
    int len;
    logic [15:0] t;
    fmode = 2'd1;
    sweep(1'b1, len, t);
    n_chk++;
    if (len !== 16) begin
      n_fail++;
      $display("FAIL len_dw1 got %0d exp 16", len);
    end
    n_chk++;
    if (t !== 16'h6996) begin
      n_fail++;
      $display("FAIL tt_xor got %h exp 6996", t);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    logic [15:0] t;
    fmode = 2'd2;
    sweep(1'b1, len, t);
    n_chk++;
    if (t !== 16'hFFFF || len !== 16) begin
      n_fail++;
      $display("FAIL tt_one got %h len %0d exp FFFF len 16", t, len);
    end
    fmode = 2'd3;
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
    n_chk++;
    if (b1.tt !== 16'h0 || b1.done !== 1'b0 || b1.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear got tt=%h done=%b busy=%b exp 0/0/1",
               b1.tt, b1.done, b1.busy);
    end
    len = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (b1.done) begin
        len = k;
        break;
      end
    end
    n_chk++;
    if (b1.tt !== 16'h0000 || len !== 16) begin
      n_fail++;
      $display("FAIL tt_zero got %h len %0d exp 0000 len 16", b1.tt, len);
    end
  endtask

  task automatic test_reset_mid();
    int len;
    logic [15:0] t;
    fmode = 2'd2;
    @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    repeat (145) @(posedge clk);
    #2;
    n_chk++;
    if ({b0.A, b0.B, b0.C, b0.D} !== 4'd7 || b0.tt !== 16'h007F) begin
      n_fail++;
      $display("FAIL pre_abort got v=%h tt=%h exp 7/007F",
               {b0.A, b0.B, b0.C, b0.D}, b0.tt);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({b0.A, b0.B, b0.C, b0.D, b0.busy, b0.done, b0.tt} !== 22'd0) begin
      n_fail++;
      $display("FAIL abort got %h exp 0",
               {b0.A, b0.B, b0.C, b0.D, b0.busy, b0.done, b0.tt});
    end
    @(negedge clk);
    rst = 1'b0;
    fmode = 2'd0;
    sweep(1'b0, len, t);
    n_chk++;
    if (len !== 320 || t !== 16'hF000) begin
      n_fail++;
      $display("FAIL post_abort got len %0d tt %h exp 320 F000", len, t);
    end
  endtask

  task automatic test_start_ignored();
    int len;
    fmode = 2'd1;
    @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    len = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      b0.start = (k == 65);
      if (b0.done) begin
        len = k;
        break;
      end
    end
    b0.start = 1'b0;
    n_chk++;
    if (len !== 320) begin
      n_fail++;
      $display("FAIL ignore_len got %0d exp 320", len);
    end
    n_chk++;
    if (b0.tt !== 16'h6996) begin
      n_fail++;
      $display("FAIL ignore_tt got %h exp 6996", b0.tt);
    end
  endtask

`ifdef SWEEP_CHECK_EN
  task automatic test_check();
    int len;
    logic [15:0] t;
    fmode = 2'd0;
    b1.expected = 16'hF001;
    sweep(1'b1, len, t);
    n_chk++;
    if (b1.mismatch_cnt !== 5'd1 || b1.match !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_bad got cnt=%0d match=%b exp 1/0", b1.mismatch_cnt, b1.match);
    end
    b1.expected = 16'hF000;
    sweep(1'b1, len, t);
    n_chk++;
    if (b1.mismatch_cnt !== 5'd0 || b1.match !== 1'b1) begin
      n_fail++;
      $display("FAIL chk_good got cnt=%0d match=%b exp 0/1", b1.mismatch_cnt, b1.match);
    end
    b1.expected = 16'h0FFF;
    sweep(1'b1, len, t);
    n_chk++;
    if (b1.mismatch_cnt !== 5'd16 || b1.match !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_all got cnt=%0d match=%b exp 16/0", b1.mismatch_cnt, b1.match);
    end
  endtask
`endif

  initial begin
    b0.start = 1'b0;
    b1.start = 1'b0;
`ifdef SWEEP_CHECK_EN
    b0.expected = 16'h0;
    b1.expected = 16'h0;
`endif
    test_reset();
    test_and_dw20();
    test_xor_dw1();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
`ifdef SWEEP_CHECK_EN
    test_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
